seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit hex seven-segment driver for the board's common-anode display.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/hex7seg.sv | 33 +++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Segment vectors are ordered A..G from bit 0.
package seg7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment decoder, active-high segments.
// Bit 0 is segment A, bit 6 is segment G.
module hex7seg
    import seg7_pkg::*;
(
    input  nibble_t nib,
    output seg_t    seg
);

    always_comb begin
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver for a common-anode display.
// Displayed value is double-buffered and swaps only on frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZS          = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_o
);

    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = idx_width(NUM_DIGITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIGIT_CYCLES - 1);
    localparam logic [DW-1:0] DIV_BLANK = DW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [DW-1:0]           div;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    frame;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_flag;

    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;

    logic [NUM_DIGITS-1:0]   lzs_dark;
    logic                    zero_run;
    nibble_t                 sel_nib;
    seg_t                    hex_seg;
    logic                    dark;

    assign tick  = (div == DIV_LAST);
    assign frame = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (tick) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // A load on the boundary cycle bypasses the pending buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_flag  <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            if (load_i) begin
                pend_val   <= value_i;
                pend_dp    <= dp_i;
                pend_blank <= blank_i;
                pend_flag  <= 1'b1;
            end
            if (frame) begin
                if (load_i) begin
                    act_val   <= value_i;
                    act_dp    <= dp_i;
                    act_blank <= blank_i;
                end else if (pend_flag) begin
                    act_val   <= pend_val;
                    act_dp    <= pend_dp;
                    act_blank <= pend_blank;
                end
                pend_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        lzs_dark = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (act_val[4*k +: 4] == 4'h0);
            lzs_dark[k] = (LZS != 0) && zero_run;
        end
    end

    assign sel_nib = act_val[{idx, 2'b00} +: 4];

    hex7seg u_hex (
        .nib (sel_nib),
        .seg (hex_seg)
    );

    // A suppressed digit with its dp set keeps its anode on to show the dot.
    always_comb begin
        dark = !enable_i
            || (div < DIV_BLANK)
            || act_blank[idx]
            || (lzs_dark[idx] && !act_dp[idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_OFF;
            dp      <= 1'b1;
            an      <= '1;
            frame_o <= 1'b0;
        end else begin
            frame_o <= frame;
            if (dark) begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                an  <= '1;
            end else begin
                seg <= lzs_dark[idx] ? SEG_OFF : ~hex_seg;
                dp  <= ~act_dp[idx];
                an  <= ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: one instance without and one
// with leading-zero suppression, both driven from the same stimulus.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * DC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;

    logic [6:0]  seg, seg_l;
    logic        dp, dp_l;
    logic [3:0]  an, an_l;
    logic        frame_o, frame_l;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .LZS(0)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .load_i(load_i),
        .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .seg(seg), .dp(dp), .an(an), .frame_o(frame_o)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .LZS(1)
    ) dut_lzs (
        .clk(clk), .rst(rst), .enable_i(enable_i), .load_i(load_i),
        .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_o(frame_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
        logic [3:0] an_l;
        logic [6:0] seg_l;
        logic       dp_l;
        logic       fr_l;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    int          n;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp, m_blk, p_blk;
    logic        p_flag;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic void lane(input int pos, input bit lzs,
                                 output logic [3:0] a, output logic [6:0] s,
                                 output logic d);
        int  dv, k;
        bit  sup, off;
        dv  = pos % DC;
        k   = (pos / DC) % ND;
        sup = lzs && (k > 0) && ((m_val >> (4 * k)) == 16'h0);
        off = !enable_i || (dv < BC) || m_blk[k] || (sup && !m_dp[k]);
        if (off) begin
            a = 4'hF;
            s = 7'h7F;
            d = 1'b1;
        end else begin
            a = ~(4'b0001 << k);
            s = sup ? 7'h7F : seg_ref(m_val[4*k +: 4]);
            d = ~m_dp[k];
        end
    endfunction

    task automatic model_reset();
        n      = 0;
        m_val  = '0;
        m_dp   = '0;
        m_blk  = '1;
        p_val  = '0;
        p_dp   = '0;
        p_blk  = '0;
        p_flag = 1'b0;
        sb.delete();
    endtask

    // Predict the outputs produced by the coming edge, then clock once.
    task automatic advance();
        exp_t e;
        lane(n, 1'b0, e.an, e.seg, e.dp);
        lane(n, 1'b1, e.an_l, e.seg_l, e.dp_l);
        e.fr   = (n % FRAME == FRAME - 1);
        e.fr_l = e.fr;
        sb.push_back(e);
        if (load_i) begin
            p_val = value_i;
            p_dp  = dp_i;
            p_blk = blank_i;
        end
        if (n % FRAME == FRAME - 1) begin
            if (load_i) begin
                m_val = value_i; m_dp = dp_i; m_blk = blank_i;
            end else if (p_flag) begin
                m_val = p_val; m_dp = p_dp; m_blk = p_blk;
            end
            p_flag = 1'b0;
        end else if (load_i) begin
            p_flag = 1'b1;
        end
        n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        int   fr_cnt;
        enable_i = 1'b1;
        load_i   = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !==
            {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state an=%h seg=%h dp=%b fr=%b want an=f seg=7f dp=1 fr=0",
                     an, seg, dp, frame_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        fr_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            advance();
            e = sb.pop_front();
            fr_cnt += int'(frame_o);
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL reset_dark n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
        end
        checks++;
        if (fr_cnt != 6) begin
            errors++;
            $display("FAIL frame_count got=%0d want=6", fr_cnt);
        end
    endtask

    task automatic test_digits();
        exp_t e;
        for (int i = 0; i < 3 * FRAME; i++) begin
            load_i  = (i < FRAME) && (n % FRAME == 5);
            value_i = 16'h12A0;
            dp_i    = 4'b0100;
            blank_i = 4'b0000;
            advance();
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL digits n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4 * FRAME; i++) begin
            load_i  = 1'b0;
            dp_i    = 4'b0000;
            if (i < FRAME && n % FRAME == 10) begin
                load_i = 1'b1; value_i = 16'h1111;
            end else if (i < FRAME && n % FRAME == 20) begin
                load_i = 1'b1; value_i = 16'h2222;
            end else if (i >= 2 * FRAME && i < 3 * FRAME && n % FRAME == FRAME - 1) begin
                load_i = 1'b1; value_i = 16'h3C3C; dp_i = 4'b1001;
            end
            advance();
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL back_to_back n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_lzs();
        exp_t e;
        for (int i = 0; i < 6 * FRAME; i++) begin
            load_i = 1'b0;
            if (n % FRAME == 3 && i < FRAME) begin
                load_i = 1'b1; value_i = 16'h0005; dp_i = 4'b0000;
            end else if (n % FRAME == 3 && i >= 2 * FRAME && i < 3 * FRAME) begin
                load_i = 1'b1; value_i = 16'h0100; dp_i = 4'b0000;
            end else if (n % FRAME == 3 && i >= 4 * FRAME && i < 5 * FRAME) begin
                load_i = 1'b1; value_i = 16'h0000; dp_i = 4'b1000;
            end
            advance();
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL lzs n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_enable();
        exp_t e;
        for (int i = 0; i < 2 * FRAME; i++) begin
            enable_i = !(i < FRAME && n % FRAME >= 12 && n % FRAME <= 14);
            advance();
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL enable n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
        end
        enable_i = 1'b1;
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   reset_done;
        reset_done = 1'b0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            load_i = 1'b0;
            if (!reset_done && n % FRAME == 8) begin
                load_i = 1'b1; value_i = 16'h0F0F; dp_i = 4'b0000;
            end else if (reset_done && n % FRAME == 7 && i < 4 * FRAME) begin
                load_i = 1'b1; value_i = 16'h00C3; dp_i = 4'b0010;
            end
            advance();
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !== e) begin
                errors++;
                $display("FAIL async_reset n=%0d got=%h want=%h", n,
                         {an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l}, e);
            end
            if (!reset_done && n % FRAME == 13) begin
                load_i = 1'b0;
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({an, seg, dp, frame_o, an_l, seg_l, dp_l, frame_l} !==
                    {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL async_reset_now an=%h seg=%h dp=%b fr=%b want an=f seg=7f dp=1 fr=0",
                             an, seg, dp, frame_o);
                end
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                reset_done = 1'b1;
            end
        end
        load_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_back_to_back();
        test_lzs();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
